// File: rtl/aq_gmii_tx_framer_pkg.sv
// aq_gmii_tx_framer_pkg: shared GEMAC framing constants and framer state encoding
package aq_gmii_tx_framer_pkg;
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_ERR, S_DROP, S_IFG
  } state_t;
endpackage

// File: rtl/aq_crc32_d8.sv
// aq_crc32_d8: combinational reflected CRC32 next-state for one input byte
module aq_crc32_d8
  import aq_gmii_tx_framer_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] nxt
);
  always_comb begin
    nxt = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) nxt = nxt[0] ? (nxt >> 1) ^ CRC_POLY : nxt >> 1;
  end
endmodule

// File: rtl/aq_gmii_tx_framer.sv
// aq_gmii_tx_framer: GMII TX framer adding preamble/SFD, padding, FCS, abort handling and IFG
module aq_gmii_tx_framer
  import aq_gmii_tx_framer_pkg::*;
#(
  parameter int IFG_BYTES = 12,
  parameter int MIN_PAD   = 1,
  parameter int MIN_LEN   = 60,
  parameter int MAX_LEN   = 1518
) (
  input  logic       tx_clk,
  input  logic       rst_b,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  input  logic       in_err,
  output logic       in_ready,
  output logic [7:0] bgmii_txd,
  output logic       bgmii_txe,
  output logic       bgmii_txer,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_abort
);
  state_t state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [7:0] sub_q, sub_d;
  logic [31:0] crc_q, crc_d, crc_nx, fcs;
  logic last_q, last_d;
  logic pend_q, pend_d;
  logic done_q, done_d;
  logic [7:0] txd_q, txd_d;
  logic txe_q, txe_d, txer_q, txer_d, abort_q, abort_d;
  aq_crc32_d8 u_crc (
    .crc  (crc_q),
    .data (state_q == S_PAD ? 8'h00 : in_data),
    .nxt  (crc_nx)
  );
  assign fcs = ~crc_q;
  assign in_ready = state_q == S_DATA || state_q == S_DROP;
  assign tx_busy = state_q != S_IDLE;
  assign bgmii_txd = txd_q;
  assign bgmii_txe = txe_q;
  assign bgmii_txer = txer_q;
  assign tx_done = done_q;
  assign tx_abort = abort_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sub_d = sub_q;
    crc_d = crc_q;
    last_d = last_q;
    pend_d = state_q == S_FCS && sub_q == 8'd3;
    done_d = pend_q;
    txd_d = 8'h00;
    txe_d = 1'b0;
    txer_d = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        crc_d = CRC_INIT;
        cnt_d = '0;
        sub_d = '0;
        state_d = in_valid ? S_PRE : S_IDLE;
      end
      S_PRE: begin
        {txd_d, txe_d} = {PRE_BYTE, 1'b1};
        sub_d = sub_q == 8'd6 ? 8'd0 : sub_q + 8'd1;
        state_d = sub_q == 8'd6 ? S_SFD : S_PRE;
      end
      S_SFD: begin
        {txd_d, txe_d} = {SFD_BYTE, 1'b1};
        state_d = S_DATA;
      end
      S_DATA: begin
        if (!in_valid || in_err || cnt_q == 11'(MAX_LEN)) begin
          {txd_d, txe_d, txer_d, abort_d} = {8'hFF, 3'b111};
          last_d = in_valid && in_last;
          state_d = S_ERR;
        end else begin
          {txd_d, txe_d} = {in_data, 1'b1};
          crc_d = crc_nx;
          cnt_d = cnt_q + {10'd0, ~&cnt_q};
          if (in_last) state_d = (MIN_PAD != 0 && cnt_q + 11'd1 < 11'(MIN_LEN)) ? S_PAD : S_FCS;
        end
      end
      S_PAD: begin
        txe_d = 1'b1;
        crc_d = crc_nx;
        cnt_d = cnt_q + 11'd1;
        state_d = cnt_q + 11'd1 == 11'(MIN_LEN) ? S_FCS : S_PAD;
      end
      S_FCS: begin
        {txd_d, txe_d} = {fcs[{sub_q[1:0], 3'b000} +: 8], 1'b1};
        sub_d = sub_q == 8'd3 ? 8'd0 : sub_q + 8'd1;
        state_d = sub_q == 8'd3 ? S_IFG : S_FCS;
      end
      S_ERR: begin
        sub_d = 8'd1;
        state_d = last_q ? S_IFG : S_DROP;
      end
      S_DROP: begin
        sub_d = '0;
        state_d = in_valid && in_last ? S_IFG : S_DROP;
      end
      S_IFG: begin
        sub_d = sub_q + 8'd1;
        state_d = sub_q >= 8'(IFG_BYTES - 1) ? S_IDLE : S_IFG;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge tx_clk or negedge rst_b)
    if (!rst_b) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      sub_q <= '0;
      crc_q <= CRC_INIT;
      last_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
      txd_q <= 8'h00;
      txe_q <= 1'b0;
      txer_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sub_q <= sub_d;
      crc_q <= crc_d;
      last_q <= last_d;
      pend_q <= pend_d;
      done_q <= done_d;
      txd_q <= txd_d;
      txe_q <= txe_d;
      txer_q <= txer_d;
      abort_q <= abort_d;
    end
endmodule
